// File: rtl/vga_timing_gen_if.sv
// Scan-position bus between the VGA timing generator (master) and its consumer (slave).
interface vga_timing_gen_if;
    logic       start;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_tick;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    modport master (
        input  start,
        output pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick, frame_cnt
    );

    modport slave (
        output start,
        input  pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered syncs and ticks.
// Optional frame counter is built only when FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic              clk_div,
    input  logic              rst_n,
    vga_timing_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, y_q;
    logic [9:0] x_nxt, y_nxt;
    logic       video_on_q, hsync_q, vsync_q, line_tick_q, frame_tick_q;
    logic       at_origin;

    // Next scan position; decodes below use it so they line up with the new counters.
    always_comb begin
        x_nxt = x_q + 10'd1;
        y_nxt = y_q;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
    end

    assign at_origin = (x_nxt == '0) && (y_nxt == '0);

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= H_LAST;
            y_q          <= V_LAST;
            video_on_q   <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else if (bus.start) begin
            x_q          <= x_nxt;
            y_q          <= y_nxt;
            video_on_q   <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
            hsync_q      <= !((x_nxt >= H_SYNC_BEG) && (x_nxt < H_SYNC_END));
            vsync_q      <= !((y_nxt >= V_SYNC_BEG) && (y_nxt < V_SYNC_END));
            line_tick_q  <= (x_nxt == '0);
            frame_tick_q <= at_origin;
        end else begin
            // Frozen scan: position and syncs hold, ticks only mark real advances.
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end
    end

    assign bus.pixel_x    = x_q;
    assign bus.pixel_y    = y_q;
    assign bus.video_on   = video_on_q;
    assign bus.hsync      = hsync_q;
    assign bus.vsync      = vsync_q;
    assign bus.line_tick  = line_tick_q;
    assign bus.frame_tick = frame_tick_q;

`ifdef FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Counts in step with frame_tick, wrapping naturally at 8 bits.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (bus.start && at_origin) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 clk_div  input  1  pixel clock (25 MHz); the design's one clock, all state changes on its rising edge.
REQ-010 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-011 start  input  1  advance enable; low freezes the scan.
REQ-012 pixel_x  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-013 pixel_y  output  10  current vertical position, 0..V_TOTAL-1.
REQ-014 video_on  output  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-015 hsync  output  1  horizontal sync, active-low.
REQ-016 vsync  output  1  vertical sync, active-low.
REQ-017 line_tick  output  1  one-cycle pulse when pixel_x advances to 0.
REQ-018 frame_tick  output  1  one-cycle pulse when position advances to (0,0).
REQ-019 frame_cnt  output  8  frame counter (see Configuration).

Function
REQ-020 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-021 All outputs SHALL be registered; video_on, hsync, vsync, line_tick and frame_tick SHALL be computed from the next position so they are cycle-aligned with pixel_x/pixel_y.
REQ-022 On each clk_div edge with start=1, pixel_x SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 and pixel_y SHALL increment.
REQ-023 When pixel_x wraps and pixel_y = V_TOTAL-1, pixel_y SHALL wrap to 0.
REQ-024 hsync SHALL be 0 iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-025 vsync SHALL be 0 iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-026 line_tick SHALL be 1 only in the cycle where pixel_x = 0 following an advance; frame_tick SHALL be 1 only in the cycle where (pixel_x,pixel_y) = (0,0) following an advance.
REQ-027 With start=0, pixel_x, pixel_y, video_on, hsync, vsync and frame_cnt SHALL hold; line_tick and frame_tick SHALL be 0.
REQ-028 start toggling mid-line SHALL resume from the held position with no skipped or repeated pixel.

Reset
REQ-029 While rst_n=0: pixel_x = H_TOTAL-1 (799), pixel_y = V_TOTAL-1 (524), video_on=0, hsync=1, vsync=1, line_tick=0, frame_tick=0, frame_cnt=0.
REQ-030 The first start=1 edge after reset release SHALL move to (0,0) with video_on=1, line_tick=1, frame_tick=1.
REQ-031 Reset asserted mid-frame SHALL immediately force REQ-029 values regardless of clk_div.

Configuration
REQ-032 Macro FRAME_CNT_EN defined: frame_cnt SHALL increment by 1 in the same cycle frame_tick asserts, wrapping 255 to 0.
REQ-033 Macro FRAME_CNT_EN undefined: frame_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-034 Reset asserted, start=1 -> outputs at REQ-029 values; first edge after release -> (0,0), video_on=1, frame_tick=1, line_tick=1.
REQ-035 Run one line -> hsync low for exactly 96 cycles with pixel_x 656..751; video_on=0 from pixel_x=640; pixel_x 799 -> 0, pixel_y +1, line_tick=1.
REQ-036 Run full frame -> frame_tick period exactly 420000 cycles; vsync low exactly 1600 cycles (pixel_y 490..491); (799,524) -> (0,0).
REQ-037 start=0 for 50 cycles at pixel_x=300 -> all outputs frozen, ticks 0; start=1 -> pixel_x=301 next edge.
REQ-038 rst_n pulsed low between clock edges at (400,200) -> outputs asynchronously forced to (799,524), hsync=vsync=1, frame_cnt=0.
REQ-039 FRAME_CNT_EN defined, 257 frames -> frame_cnt reads 1 after 255->0 wrap; undefined -> frame_cnt=0 throughout.
